// File: rtl/clock_enables.sv
// CPU clock / strobe and ULA clock-enable generator from clk_main.
// Optional CLK_CONTENTION_EN adds cpu_wait_req to stall the CPU rise edge.
module clock_enables #(
  parameter int BASE_DIV = 8,
  parameter int ULA_DIV  = 2
) (
  input  logic       clk_main,
  input  logic       reset,
  input  logic [1:0] cpu_mode,
  input  logic       ula_turbo,
`ifdef CLK_CONTENTION_EN
  input  logic       cpu_wait_req,
`endif
  output logic       clk_cpu,
  output logic       cpu_ce_rise,
  output logic       cpu_ce_fall,
  output logic [1:0] cpu_mode_active,
  output logic       ula_ce
);

  localparam int CW = $clog2(BASE_DIV);
  localparam int UW = (ULA_DIV > 1) ? $clog2(ULA_DIV) : 1;

  typedef logic [CW-1:0] cnt_t;
  typedef logic [UW-1:0] ucnt_t;

  localparam cnt_t  CNT_RST  = cnt_t'(BASE_DIV / 2);
  localparam ucnt_t ULA_LAST = ucnt_t'(ULA_DIV - 1);

  function automatic int period_of(input logic [1:0] m);
    int p;
    p = BASE_DIV >> m;
    if (p < 2) p = 2;
    return p;
  endfunction

  cnt_t  cnt;
  cnt_t  p_last;
  cnt_t  p_half;
  logic  stall;
  ucnt_t ula_cnt;

  always_comb begin
    p_last = cnt_t'(period_of(cpu_mode_active) - 1);
    p_half = cnt_t'(period_of(cpu_mode_active) / 2 - 1);
`ifdef CLK_CONTENTION_EN
    stall  = cpu_wait_req;
`else
    stall  = 1'b0;
`endif
  end

  // Mode is only adopted at a rise, so periods never get cut short.
  always_ff @(posedge clk_main or posedge reset) begin
    if (reset) begin
      cnt             <= CNT_RST;
      clk_cpu         <= 1'b0;
      cpu_ce_rise     <= 1'b0;
      cpu_ce_fall     <= 1'b0;
      cpu_mode_active <= 2'd0;
    end else if (cnt == p_last) begin
      cpu_ce_fall <= 1'b0;
      if (stall) begin
        cpu_ce_rise <= 1'b0;
      end else begin
        cnt             <= '0;
        clk_cpu         <= 1'b1;
        cpu_ce_rise     <= 1'b1;
        cpu_mode_active <= cpu_mode;
      end
    end else if (cnt == p_half) begin
      cnt         <= cnt + cnt_t'(1);
      clk_cpu     <= 1'b0;
      cpu_ce_rise <= 1'b0;
      cpu_ce_fall <= 1'b1;
    end else begin
      cnt         <= cnt + cnt_t'(1);
      cpu_ce_rise <= 1'b0;
      cpu_ce_fall <= 1'b0;
    end
  end

  always_ff @(posedge clk_main or posedge reset) begin
    if (reset) begin
      ula_cnt <= '0;
      ula_ce  <= 1'b0;
    end else if (ula_cnt == ULA_LAST) begin
      ula_cnt <= '0;
      ula_ce  <= 1'b1;
    end else begin
      ula_cnt <= ula_cnt + ucnt_t'(1);
      ula_ce  <= ula_turbo;
    end
  end

endmodule

// File: tb/tb_clock_enables.sv
// Scoreboard bench for clock_enables: event-schedule reference model,
// randomized modes/turbo (and wait requests under CLK_CONTENTION_EN).
module tb_clock_enables;

  localparam int BASE_DIV = 8;
  localparam int ULA_DIV  = 2;

  typedef struct packed {
    logic       clk;
    logic       rise;
    logic       fall;
    logic [1:0] mode;
    logic       ula;
  } exp_t;

  logic       clk_main;
  logic       reset;
  logic [1:0] cpu_mode;
  logic       ula_turbo;
  logic       cpu_wait_req;
  logic       clk_cpu;
  logic       cpu_ce_rise;
  logic       cpu_ce_fall;
  logic [1:0] cpu_mode_active;
  logic       ula_ce;

  int tests;
  int fails;
  int popped;
  exp_t q[$];

  // reference model: absolute edge times of the next rise / fall
  int t;
  int next_rise;
  int next_fall;
  bit clk_e;
  int mode_e;

  clock_enables #(
    .BASE_DIV(BASE_DIV),
    .ULA_DIV (ULA_DIV)
  ) dut (
    .clk_main       (clk_main),
    .reset          (reset),
    .cpu_mode       (cpu_mode),
    .ula_turbo      (ula_turbo),
`ifdef CLK_CONTENTION_EN
    .cpu_wait_req   (cpu_wait_req),
`endif
    .clk_cpu        (clk_cpu),
    .cpu_ce_rise    (cpu_ce_rise),
    .cpu_ce_fall    (cpu_ce_fall),
    .cpu_mode_active(cpu_mode_active),
    .ula_ce         (ula_ce)
  );

  initial begin
    clk_main = 1'b0;
    forever #5 clk_main = ~clk_main;
  end

  function automatic int period_of(input int m);
    int p;
    p = BASE_DIV >> m;
    return (p < 2) ? 2 : p;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    t         = 0;
    next_rise = BASE_DIV / 2;
    next_fall = -1;
    clk_e     = 1'b0;
    mode_e    = 0;
  endtask

  // Called at a negedge: drive inputs, predict the next posedge, wait.
  task automatic cycle(input int m, input bit turbo, input bit w);
    exp_t e;
    bit r;
    bit f;
    int p;
    cpu_mode     = 2'(m);
    ula_turbo    = turbo;
`ifdef CLK_CONTENTION_EN
    cpu_wait_req = w;
`else
    cpu_wait_req = 1'b0;
`endif
    t++;
    r = 1'b0;
    f = 1'b0;
    if (t == next_rise) begin
      if (cpu_wait_req) begin
        next_rise++;
      end else begin
        r         = 1'b1;
        mode_e    = m;
        p         = period_of(m);
        next_fall = t + p / 2;
        next_rise = t + p;
        clk_e     = 1'b1;
      end
    end else if (t == next_fall) begin
      f     = 1'b1;
      clk_e = 1'b0;
    end
    e.clk  = clk_e;
    e.rise = r;
    e.fall = f;
    e.mode = 2'(mode_e);
    e.ula  = turbo ? 1'b1 : ((t % ULA_DIV) == 0);
    q.push_back(e);
    @(negedge clk_main);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_clk"},  int'(clk_cpu), 0);
    chk({tag, "_rise"}, int'(cpu_ce_rise), 0);
    chk({tag, "_fall"}, int'(cpu_ce_fall), 0);
    chk({tag, "_mode"}, int'(cpu_mode_active), 0);
    chk({tag, "_ula"},  int'(ula_ce), 0);
  endtask

  task automatic rnd_cycle();
    cycle(int'($urandom_range(0, 3)), bit'($urandom_range(0, 3) == 0),
          bit'($urandom_range(0, 3) == 0));
  endtask

  // monitor
  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(posedge clk_main);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        a = '{clk_cpu, cpu_ce_rise, cpu_ce_fall, cpu_mode_active, ula_ce};
        popped++;
        tests++;
        if (a != e) begin
          fails++;
          $display("FAIL cycle%0d: got clk=%b rise=%b fall=%b mode=%0d ula=%b want clk=%b rise=%b fall=%b mode=%0d ula=%b",
                   popped, a.clk, a.rise, a.fall, a.mode, a.ula,
                   e.clk, e.rise, e.fall, e.mode, e.ula);
        end
        tests++;
        if (cpu_ce_rise && cpu_ce_fall) begin
          fails++;
          $display("FAIL strobe_overlap: got rise=1 fall=1 want not both");
        end
      end
    end
  end

  initial begin
    tests        = 0;
    fails        = 0;
    popped       = 0;
    reset        = 1'b1;
    cpu_mode     = 2'd0;
    ula_turbo    = 1'b0;
    cpu_wait_req = 1'b0;
    model_reset();
    #1;
    chk_reset_vals("por");
    #20;
    @(negedge clk_main);
    reset = 1'b0;
    model_reset();
    // mode 0 steady, then 0->1 requested mid-period
    for (int i = 0; i < 21; i++) cycle(0, 1'b0, 1'b0);
    for (int i = 0; i < 24; i++) cycle(1, 1'b0, 1'b0);
    // mode 3 clamps to P=2, with turbo on/off
    for (int i = 0; i < 12; i++) cycle(3, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) cycle(3, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) cycle(0, 1'b1, 1'b0);
    for (int i = 0; i < 400; i++) rnd_cycle();
    // run until the CPU clock is in a high phase
    for (int i = 0; i < 50 && !clk_e; i++) cycle(0, 1'b0, 1'b0);
    @(posedge clk_main);
    #3;
    chk("pre_reset_clk_high", int'(clk_cpu), int'(clk_e));
    reset = 1'b1;
    #1;
    chk_reset_vals("async");
    repeat (2) @(posedge clk_main);
    @(negedge clk_main);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 20; i++) cycle(0, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) rnd_cycle();
    repeat (2) @(posedge clk_main);
    #2;
    chk("queue_drained", q.size(), 0);
    chk("monitor_active", int'(popped > 700), 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
